// File: rtl/rob_complete_arb_pkg.sv
// rtl/rob_complete_arb_pkg.sv - shared types for the ROB completion arbiter
//
// Purpose: completion/nuke packet layouts, ROB id width and arbiter sizing.
// Ports: none (package).
package rob_complete_arb_pkg;

    localparam int RB_CMPL_NUM_REQ = 3;
    localparam int RB_CMPL_Q_DEPTH = 2;

    // 16-entry ROB plus one wrap bit, so 0x10 and 0x00 are different ids.
    localparam int ROB_ID_W = 5;

    typedef logic [$clog2(RB_CMPL_NUM_REQ)-1:0] t_cmpl_req_id;
    typedef logic [ROB_ID_W-1:0]                t_rob_id;

    typedef struct packed {
        logic       valid;
        t_rob_id    robid;
        logic       exception;
        logic [3:0] status;
    } t_rob_complete_pkt;

    typedef struct packed {
        logic    valid;
        t_rob_id robid;
    } t_nuke_pkt;

endpackage

// File: rtl/rob_cmpl_q.sv
// rtl/rob_cmpl_q.sv - per-requester completion FIFO
//
// Purpose: DEPTH-entry FIFO of completion packets; flush beats push/pop.
// Ports:
//   clk         clock
//   flush       empty the queue (reset or nuke)
//   push        enqueue push_pkt
//   push_pkt    packet to enqueue
//   pop         dequeue the head
//   head        oldest queued packet (valid only when count != 0)
//   count       number of queued packets
//   slot_robid  robid held in each storage slot
//   slot_used   slot currently holds a queued packet
module rob_cmpl_q
    import rob_complete_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         flush,
    input  logic                         push,
    input  t_rob_complete_pkt            push_pkt,
    input  logic                         pop,
    output t_rob_complete_pkt            head,
    output logic [$clog2(DEPTH):0]       count,
    output t_rob_id [DEPTH-1:0]          slot_robid,
    output logic [DEPTH-1:0]             slot_used
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    t_rob_complete_pkt mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_pkt;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;

    // A slot is live when its distance from the read pointer is below count;
    // pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            logic [PW-1:0] offset;
            offset        = PW'(j) - rd_ptr;
            slot_robid[j] = mem[j].robid;
            slot_used[j]  = ({1'b0, offset} < count_q);
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (flush)
        push |-> (count_q < CW'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (flush)
        pop |-> (count_q != '0));

endmodule

// File: rtl/rob_complete_arb.sv
// rtl/rob_complete_arb.sv - arbitrates requester completions onto the ROB port
//
// Purpose: one completion per cycle onto complete_rb0; the queue whose head
// matches oldest_robid wins, otherwise round-robin from rr_ptr. Nuke drops all.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   req_valid[i]   requester i offers req_pkt[i]
//   req_pkt[i]     completion packet from requester i
//   req_ready[i]   queue i can accept this cycle
//   oldest_robid   ROB head id
//   nuke_rb1       flush request (.valid only)
//   complete_rb0   granted packet, .valid qualifies
//   arb_busy       any queue non-empty
module rob_complete_arb
    import rob_complete_arb_pkg::*;
#(
    parameter int NUM_REQ = RB_CMPL_NUM_REQ,
    parameter int Q_DEPTH = RB_CMPL_Q_DEPTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  t_rob_complete_pkt [NUM_REQ-1:0]    req_pkt,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  t_rob_id                            oldest_robid,
    input  t_nuke_pkt                          nuke_rb1,
    output t_rob_complete_pkt                  complete_rb0,
    output logic                               arb_busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(Q_DEPTH) + 1;

    logic                        flush;
    logic [NUM_REQ-1:0]          push;
    logic [NUM_REQ-1:0]          pop;
    logic [NUM_REQ-1:0]          nonempty;
    logic [NUM_REQ-1:0]          match;
    t_rob_complete_pkt           head [NUM_REQ];
    logic [CW-1:0]               count [NUM_REQ];
    t_rob_id [Q_DEPTH-1:0]       slot_robid [NUM_REQ];
    logic [Q_DEPTH-1:0]          slot_used [NUM_REQ];

    logic [IDW-1:0]              rr_ptr;
    logic [IDW-1:0]              grant_id;
    logic                        grant_vld;
    logic                        found;
    int                          rr_idx;
    t_rob_complete_pkt           head_sel;
    logic                        dup_robid;

    assign flush = reset | nuke_rb1.valid;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_q
        // Readiness looks at state only: a pop this cycle does not open a slot.
        assign req_ready[i] = ~reset & (count[i] < CW'(Q_DEPTH));
        assign push[i]      = req_valid[i] & req_ready[i] & ~nuke_rb1.valid;
        assign nonempty[i]  = (count[i] != '0);
        assign match[i]     = nonempty[i] & (head[i].robid == oldest_robid);
        assign pop[i]       = grant_vld & (grant_id == IDW'(i));

        rob_cmpl_q #(
            .DEPTH(Q_DEPTH)
        ) u_q (
            .clk        (clk),
            .flush      (flush),
            .push       (push[i]),
            .push_pkt   (req_pkt[i]),
            .pop        (pop[i]),
            .head       (head[i]),
            .count      (count[i]),
            .slot_robid (slot_robid[i]),
            .slot_used  (slot_used[i])
        );
    end

    // Oldest-match first (lowest index), else first non-empty queue at or
    // after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_id = '0;
        found    = 1'b0;
        rr_idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && match[i]) begin
                grant_id = IDW'(i);
                found    = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = int'(rr_ptr) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!found && nonempty[IDW'(rr_idx)]) begin
                grant_id = IDW'(rr_idx);
                found    = 1'b1;
            end
        end
    end

    assign grant_vld = (|nonempty) & ~nuke_rb1.valid & ~reset;
    assign arb_busy  = |nonempty;

    always_comb begin
        head_sel           = head[grant_id];
        complete_rb0       = head_sel;
        complete_rb0.valid = grant_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Nuke robid and the stored valid bit carry no meaning here.
    logic unused_fields;
    assign unused_fields = ^{nuke_rb1.robid, head_sel.valid};

    always_comb begin
        dup_robid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int a = 0; a < Q_DEPTH; a++) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    for (int b = 0; b < Q_DEPTH; b++) begin
                        if (((i * Q_DEPTH + a) < (j * Q_DEPTH + b)) &&
                            slot_used[i][a] && slot_used[j][b] &&
                            (slot_robid[i][a] == slot_robid[j][b])) begin
                            dup_robid = 1'b1;
                        end
                    end
                end
            end
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (reset)
        $onehot0(pop));
    a_valid_pops: assert property (@(posedge clk) disable iff (reset)
        complete_rb0.valid |-> (|pop));
    a_unique_robid: assert property (@(posedge clk) disable iff (reset)
        !dup_robid);

endmodule
